// File: rtl/regfile_sb.sv
// Register file with issue scoreboard: 31 GPRs plus a 64-bit HI/LO register, combinational
// read ports with same-cycle write bypass, and one busy bit per architectural destination.

module regfile_sb_rport (
  input  logic [5:0]        addr,
  input  logic [32:0][31:0] lo_q,
  input  logic [32:0]       busy_q,
  input  logic [32:0]       byp_hit,
  input  logic [32:0][31:0] byp_lo,
  output logic [31:0]       data,
  output logic              ready
);
  always_comb begin
    data  = '0;
    ready = 1'b1;
    // address 0 and 33..63 are hardwired zero / always ready
    if (addr != 6'd0 && addr <= 6'd32) begin
      if (byp_hit[addr]) begin
        data = byp_lo[addr];
      end else begin
        data  = lo_q[addr];
        ready = !busy_q[addr];
      end
    end
  end
endmodule

module regfile_sb #(
  parameter int NR = 16,
  parameter int NW = 4,
  parameter int NI = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NR*6-1:0]  raddr,
  output logic [NR*32-1:0] rdata,
  output logic [NR-1:0]    rready,
  output logic [63:0]      hilo_rdata,
  output logic             hilo_ready,
  input  logic [NW-1:0]    we,
  input  logic [NW*6-1:0]  waddr,
  input  logic [NW*64-1:0] wdata,
  input  logic [NI-1:0]    iss_valid,
  input  logic [NI*6-1:0]  iss_addr,
  input  logic             flush
);
  logic [31:0][31:0] gpr_q;
  logic [63:0]       hilo_q;
  logic [32:0]       busy_q, busy_d;
  logic [32:0]       wr_hit;
  logic [32:0][31:0] wr_lo;
  logic [31:0]       wr_hi;
  logic [32:0][31:0] lo_q;

  // Resolve write ports per address; later ports overwrite earlier ones so the highest index wins.
  // Writes are masked while in reset so nothing leaks through the bypass either.
  always_comb begin
    wr_hit = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    for (int p = 0; p < NW; p++) begin
      if (resetn && we[p] && waddr[6*p +: 6] != 6'd0 && waddr[6*p +: 6] <= 6'd32) begin
        wr_hit[waddr[6*p +: 6]] = 1'b1;
        wr_lo[waddr[6*p +: 6]]  = wdata[64*p +: 32];
        if (waddr[6*p +: 6] == 6'd32) wr_hi = wdata[64*p+32 +: 32];
      end
    end
  end

  // Issue beats write on the same address (new producer); flush beats everything.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    for (int k = 0; k < NI; k++) begin
      if (iss_valid[k] && iss_addr[6*k +: 6] != 6'd0 && iss_addr[6*k +: 6] <= 6'd32)
        busy_d[iss_addr[6*k +: 6]] = 1'b1;
    end
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpr_q  <= '0;
      hilo_q <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      for (int a = 1; a < 32; a++)
        if (wr_hit[a]) gpr_q[a] <= wr_lo[a];
      if (wr_hit[32]) hilo_q <= {wr_hi, wr_lo[32]};
    end
  end

  // Read ports see LO for address 32; the full pair is on hilo_rdata.
  assign lo_q = {hilo_q[31:0], gpr_q};

  assign hilo_rdata = wr_hit[32] ? {wr_hi, wr_lo[32]} : hilo_q;
  assign hilo_ready = wr_hit[32] | !busy_q[32];

  for (genvar i = 0; i < NR; i++) begin : g_rport
    regfile_sb_rport u_rport (
      .addr    (raddr[6*i +: 6]),
      .lo_q    (lo_q),
      .busy_q  (busy_q),
      .byp_hit (wr_hit),
      .byp_lo  (wr_lo),
      .data    (rdata[32*i +: 32]),
      .ready   (rready[i])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random checks of regfile_sb against an array-based reference model.

module tb_regfile_sb;
  localparam int NR = 16, NW = 4, NI = 2;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NR*6-1:0]  raddr = '0;
  logic [NR*32-1:0] rdata;
  logic [NR-1:0]    rready;
  logic [63:0]      hilo_rdata;
  logic             hilo_ready;
  logic [NW-1:0]    we = '0;
  logic [NW*6-1:0]  waddr = '0;
  logic [NW*64-1:0] wdata = '0;
  logic [NI-1:0]    iss_valid = '0;
  logic [NI*6-1:0]  iss_addr = '0;
  logic             flush = 1'b0;

  int nvec = 0, nerr = 0;

  logic [31:0] m_gpr[32];
  logic [63:0] m_hilo;
  bit          m_busy[33];

  regfile_sb #(.NR(NR), .NW(NW), .NI(NI)) dut (
    .clk(clk), .resetn(resetn), .raddr(raddr), .rdata(rdata), .rready(rready),
    .hilo_rdata(hilo_rdata), .hilo_ready(hilo_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int a = 0; a < 32; a++) m_gpr[a] = '0;
    m_hilo = '0;
    for (int a = 0; a < 33; a++) m_busy[a] = 1'b0;
  endfunction

  // Value a same-cycle write would forward to address a (last matching port wins).
  function automatic void exp_byp(input logic [5:0] a, output bit hit, output logic [63:0] v);
    hit = 1'b0;
    v   = '0;
    if (resetn !== 1'b1) return;
    for (int p = 0; p < NW; p++)
      if (we[p] && waddr[6*p +: 6] == a) begin
        hit = 1'b1;
        v   = wdata[64*p +: 64];
      end
  endfunction

  function automatic void exp_rd(input logic [5:0] a, output logic [31:0] d, output logic r);
    bit hit;
    logic [63:0] v;
    d = '0;
    r = 1'b1;
    if (a == 6'd0 || a > 6'd32) return;
    exp_byp(a, hit, v);
    if (hit) d = v[31:0];
    else begin
      d = (a == 6'd32) ? m_hilo[31:0] : m_gpr[a[4:0]];
      r = !m_busy[a];
    end
  endfunction

  task automatic check_reads(input string tag);
    logic [31:0] d;
    logic r, hr;
    bit hit;
    logic [63:0] v;
    for (int i = 0; i < NR; i++) begin
      exp_rd(raddr[6*i +: 6], d, r);
      chk($sformatf("%s_rdata%0d", tag, i), {32'h0, rdata[32*i +: 32]}, {32'h0, d});
      chk($sformatf("%s_rready%0d", tag, i), {63'h0, rready[i]}, {63'h0, r});
    end
    exp_byp(6'd32, hit, v);
    hr = hit | !m_busy[32];
    chk({tag, "_hilo"}, hilo_rdata, hit ? v : m_hilo);
    chk({tag, "_hilo_rdy"}, {63'h0, hilo_ready}, {63'h0, hr});
  endtask

  // Advance one clock edge and move the model by the rules of a write/issue/flush cycle.
  task automatic step();
    logic [31:0] ng[32];
    logic [63:0] nh;
    bit nb[33];
    bit hit;
    logic [63:0] v;
    ng = m_gpr;
    nh = m_hilo;
    nb = m_busy;
    for (int a = 1; a <= 32; a++) begin
      exp_byp(6'(a), hit, v);
      if (hit) begin
        if (a == 32) nh = v; else ng[a] = v[31:0];
        nb[a] = 1'b0;
      end
    end
    for (int k = 0; k < NI; k++)
      if (iss_valid[k] && iss_addr[6*k +: 6] >= 6'd1 && iss_addr[6*k +: 6] <= 6'd32)
        nb[iss_addr[6*k +: 6]] = 1'b1;
    if (flush) for (int a = 0; a < 33; a++) nb[a] = 1'b0;
    @(posedge clk);
    #1;
    m_gpr = ng;
    m_hilo = nh;
    m_busy = nb;
  endtask

  task automatic idle();
    we = '0; iss_valid = '0; flush = 1'b0;
  endtask

  function automatic logic [5:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 13) return 6'd32;
    if (r == 14) return 6'd40;
    if (r == 15) return 6'd0;
    return 6'(r);
  endfunction

  initial begin
    model_reset();
    // reset: inputs active but ignored
    for (int i = 0; i < NR; i++) raddr[6*i +: 6] = 6'(i + 1);
    we = '1; waddr = {6'd5, 6'd32, 6'd2, 6'd1}; wdata = {NW{64'hDEAD_BEEF_0BAD_F00D}};
    iss_valid = '1; iss_addr = {6'd2, 6'd3};
    #3;
    chk("rst_rdata", {32'h0, rdata[31:0]}, 64'h0);
    chk("rst_rready", {48'h0, rready}, {48'h0, 16'hFFFF});
    chk("rst_hilo", hilo_rdata, 64'h0);
    check_reads("rst");
    @(posedge clk); #1;
    check_reads("rst_edge");
    idle();
    resetn = 1'b1;
    #1;
    check_reads("post_rst");

    // single write, bypass then array
    raddr[6*3 +: 6] = 6'd5;
    we = 4'b0001; waddr[0 +: 6] = 6'd5; wdata[0 +: 64] = 64'h0000_0000_1234_5678;
    #1;
    chk("byp_r5", {32'h0, rdata[32*3 +: 32]}, 64'h1234_5678);
    chk("byp_r5_rdy", {63'h0, rready[3]}, 64'h1);
    check_reads("wr1");
    step(); idle(); #1;
    chk("arr_r5", {32'h0, rdata[32*3 +: 32]}, 64'h1234_5678);
    check_reads("wr1_after");

    // two ports to r7: port 3 wins
    raddr[0 +: 6] = 6'd7;
    we = 4'b1001; waddr[0 +: 6] = 6'd7; waddr[18 +: 6] = 6'd7;
    wdata[0 +: 64] = 64'h1111; wdata[192 +: 64] = 64'h3333;
    #1;
    chk("prio_byp", {32'h0, rdata[31:0]}, 64'h3333);
    step(); idle(); #1;
    chk("prio_arr", {32'h0, rdata[31:0]}, 64'h3333);

    // scoreboard on r9
    raddr[0 +: 6] = 6'd9;
    iss_valid = 2'b01; iss_addr[0 +: 6] = 6'd9;
    step(); idle(); #1;
    chk("busy_r9", {63'h0, rready[0]}, 64'h0);
    we = 4'b0100; waddr[12 +: 6] = 6'd9; wdata[128 +: 64] = 64'h99;
    #1;
    chk("wr_r9_byp_rdy", {63'h0, rready[0]}, 64'h1);
    check_reads("r9w");
    step(); idle(); #1;
    chk("r9_cleared", {63'h0, rready[0]}, 64'h1);
    iss_valid = 2'b10; iss_addr[6 +: 6] = 6'd9;
    we = 4'b0001; waddr[0 +: 6] = 6'd9; wdata[0 +: 64] = 64'h77;
    step(); idle(); #1;
    chk("r9_iss_wr", {63'h0, rready[0]}, 64'h0);
    chk("r9_iss_wr_data", {32'h0, rdata[31:0]}, 64'h77);

    // HI/LO and special addresses
    raddr[0 +: 6] = 6'd0; raddr[6 +: 6] = 6'd40;
    we = 4'b0010; waddr[6 +: 6] = 6'd32; wdata[64 +: 64] = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("hilo_byp", hilo_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    check_reads("hilo");
    step(); idle(); #1;
    chk("hilo_arr", hilo_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("a0_data", {32'h0, rdata[31:0]}, 64'h0);
    chk("a40_data", {32'h0, rdata[63:32]}, 64'h0);
    chk("a0_a40_rdy", {62'h0, rready[1:0]}, 64'h3);

    // flush drops everything, including an issue in the same cycle
    for (int i = 0; i < 6; i++) raddr[6*i +: 6] = 6'(i + 1);
    iss_valid = 2'b11; iss_addr = {6'd2, 6'd1};
    step();
    iss_addr = {6'd4, 6'd3};
    step(); idle(); #1;
    chk("pre_flush_busy", {60'h0, rready[3:0]}, 64'h0);
    flush = 1'b1; iss_valid = 2'b01; iss_addr[0 +: 6] = 6'd6;
    step(); idle(); #1;
    chk("flush_rdy", {58'h0, rready[5:0]}, 64'h3F);
    check_reads("flush");

    // asynchronous reset mid-operation
    raddr[0 +: 6] = 6'd3; raddr[6 +: 6] = 6'd4;
    we = 4'b0001; waddr[0 +: 6] = 6'd3; wdata[0 +: 64] = 64'hFF;
    iss_valid = 2'b10; iss_addr[6 +: 6] = 6'd4;
    step(); idle(); #1;
    chk("r3_loaded", {32'h0, rdata[31:0]}, 64'hFF);
    chk("r4_busy", {63'h0, rready[1]}, 64'h0);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_r3", {32'h0, rdata[31:0]}, 64'h0);
    chk("rst_r4_rdy", {63'h0, rready[1]}, 64'h1);
    chk("rst_hilo_mid", hilo_rdata, 64'h0);
    check_reads("midrst");
    resetn = 1'b1;
    #1;

    // random traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) raddr[6*i +: 6] = rnd_addr();
      we = 4'($urandom);
      for (int p = 0; p < NW; p++) begin
        waddr[6*p +: 6] = rnd_addr();
        wdata[64*p +: 64] = {$urandom, $urandom};
      end
      iss_valid = 2'($urandom);
      for (int k = 0; k < NI; k++) iss_addr[6*k +: 6] = rnd_addr();
      flush = ($urandom_range(0, 15) == 0);
      #1;
      check_reads("rnd");
      step();
    end
    idle(); #1;
    check_reads("final");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter NR, default 16, number of read ports.
REQ-002 SHALL have parameter NW, default 4, number of write ports.
REQ-003 SHALL have parameter NI, default 2, number of issue (busy-set) ports.
REQ-004 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port raddr  in  NR*6  packed read addresses, port i at [6i+5:6i].
REQ-007 SHALL have port rdata  out  NR*32  packed read data.
REQ-008 SHALL have port rready  out  NR  per-port operand-ready flag.
REQ-009 SHALL have port hilo_rdata  out  64  HI/LO value, {HI,LO}.
REQ-010 SHALL have port hilo_ready  out  1  HI/LO ready flag.
REQ-011 SHALL have port we  in  NW  write enables.
REQ-012 SHALL have port waddr  in  NW*6  packed write addresses.
REQ-013 SHALL have port wdata  in  NW*64  packed write data.
REQ-014 SHALL have port iss_valid  in  NI  issue strobes.
REQ-015 SHALL have port iss_addr  in  NI*6  packed destination addresses to mark busy.
REQ-016 SHALL have port flush  in  1  clears the whole scoreboard.

Function
REQ-017 SHALL map addresses as follows: 0 reads 0, 1..31 are 32-bit GPRs, 32 is the 64-bit HI/LO register, and 33..63 are reserved.
REQ-018 SHALL treat address 0 and reserved addresses as never written and never busy, with rdata 0 and rready 1.
REQ-019 SHALL write GPRs with wdata[31:0] on a rising edge when we=1.
REQ-020 SHALL write all 64 bits of wdata to HI/LO.
REQ-021 SHALL let the highest-index write port win when several write ports target the same address in one cycle.
REQ-022 SHALL make reads combinational (0-cycle latency).
REQ-023 SHALL bypass a same-cycle write to the read address: rdata = winning port's wdata[31:0] and rready = 1.
REQ-024 SHALL return stored data otherwise, with rready = !busy[addr].
REQ-025 SHALL produce hilo_rdata from the 64-bit bypass if a write to address 32 is present, else from the stored value; hilo_ready SHALL be derived the same way as REQ-023/REQ-024.
REQ-026 SHALL keep one busy bit per address 1..32.
REQ-027 SHALL set busy[a] on the next edge when iss_valid[k]=1 with iss_addr[k]=a (a in 1..32).
REQ-028 SHALL clear busy[a] on the next edge when any write port writes a.
REQ-029 SHALL leave busy[a] set (the new producer wins) when an issue and a write target the same a in one cycle; the data write still occurs.
REQ-030 SHALL set busy once, with no error, when multiple issue ports name the same address.
REQ-031 SHALL clear every busy bit on the next edge when flush=1, ignore all issues that cycle, and still perform that cycle's writes.
REQ-032 SHALL ignore issues to address 0 or reserved addresses.
REQ-033 SHALL make stored data visible through the array one cycle after the write and through the bypass in the same cycle.

Reset
REQ-034 SHALL immediately clear all GPRs, HI/LO and busy bits while resetn=0, independent of clk.
REQ-035 SHALL drive all rdata/hilo_rdata to 0 and all rready/hilo_ready to 1 during and after reset.
REQ-036 SHALL ignore we, iss_valid and flush while resetn=0.
REQ-037 SHALL, when reset is asserted mid-operation, discard pending busy state and the in-flight write of that cycle.

Verification
REQ-038 SHALL be verified by: write r5=0x12345678 via port 0, read same cycle on port 3 -> rdata=0x12345678 and rready=1; next cycle read -> 0x12345678 from the array.
REQ-039 SHALL be verified by: we[0] and we[3] both to r7 with 0x1111 and 0x3333 -> r7=0x3333 afterwards; bypass also shows 0x3333.
REQ-040 SHALL be verified by: issue r9 -> next cycle rready for r9 = 0; write r9 -> bypass ready=1 and busy cleared next cycle; issue and write r9 together -> busy remains 1.
REQ-041 SHALL be verified by: write addr 32 with 0xAAAA_BBBB_CCCC_DDDD -> hilo_rdata shows the value the same cycle and after; read of addr 0 or 40 -> 0 and ready 1.
REQ-042 SHALL be verified by: issue r1..r4, then flush together with a new issue of r6 -> all busy 0 including r6.
REQ-043 SHALL be verified by: load r3=0xFF and busy r4, then pulse resetn low between edges -> r3 reads 0 and r4 ready=1 immediately.
